lsu_ctrl: RTL and testbench

//  Load/store sequencer between the EX_to_WB register and the data-memory port (req/gnt/rvalid).

---
 rtl/riscv_lsu_pkg.sv | 40 ++++
 rtl/lsu_load_align.sv | 33 +++
 rtl/lsu_ctrl.sv | 123 ++++++++++++
 tb/tb_lsu_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_lsu_pkg.sv
// Shared types and helpers for the load/store sequencer.
package riscv_lsu_pkg;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_LB   = 3'd1,
    LD_LH   = 3'd2,
    LD_LW   = 3'd3,
    LD_LBU  = 3'd4,
    LD_LHU  = 3'd5
  } load_type_e;

  typedef enum logic [1:0] {
    ST_NONE = 2'd0,
    ST_SB   = 2'd1,
    ST_SH   = 2'd2,
    ST_SW   = 2'd3
  } store_type_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  function automatic logic [3:0] be_gen(input size_e size, input logic [1:0] offset);
    case (size)
      SZ_B:    be_gen = 4'b0001 << offset;
      SZ_H:    be_gen = offset[1] ? 4'b1100 : 4'b0011;
      default: be_gen = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/halfword lane of a read word and sign/zero-extends it.
module lsu_load_align
  import riscv_lsu_pkg::*;
(
  input  logic [2:0]  load_type,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    case (load_type)
      LD_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  result = {24'd0, byte_sel};
      LD_LH:   result = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  result = {16'd0, half_sel};
      LD_LW:   result = rdata;
      default: result = 32'd0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one data-memory transaction per op, stalls the pipeline until rvalid.
// Optional LSU_MISALIGN_EXC_EN: misaligned H/W accesses raise misaligned_o instead of issuing.
module lsu_ctrl
  import riscv_lsu_pkg::*;
#(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            load_type_i,
  input  logic [1:0]            store_type_i,
  input  logic [WORD_WIDTH-1:0] addr_i,
  input  logic [WORD_WIDTH-1:0] wdata_i,
  output logic                  stall_o,
  output logic                  done_o,
  output logic [WORD_WIDTH-1:0] rdata_o,
`ifdef LSU_MISALIGN_EXC_EN
  output logic                  misaligned_o,
`endif
  output logic                  data_req_o,
  output logic [WORD_WIDTH-1:0] data_addr_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [WORD_WIDTH-1:0] data_wdata_o,
  input  logic [WORD_WIDTH-1:0] data_rdata_i,
  input  logic                  data_rvalid_i,
  input  logic                  data_gnt_i
);

  lsu_state_e state, state_nxt;
  logic [2:0] ld_q;
  logic [1:0] off_q;

  logic       is_load, is_store, op, misaligned, mis_pulse;
  logic       issue, grant, resp_done;
  size_e      size;
  logic [1:0] off;
  logic [WORD_WIDTH-1:0] wdata_lane, load_result;

  always_comb begin
    is_load  = load_type_i inside {LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU};
    is_store = (store_type_i != ST_NONE);
    op       = is_load | is_store;

    // A load takes priority; a simultaneous store request is dropped.
    size = SZ_W;
    if (is_load) begin
      if (load_type_i == LD_LB || load_type_i == LD_LBU)      size = SZ_B;
      else if (load_type_i == LD_LH || load_type_i == LD_LHU) size = SZ_H;
    end else if (store_type_i == ST_SB) begin
      size = SZ_B;
    end else if (store_type_i == ST_SH) begin
      size = SZ_H;
    end

    off        = addr_i[1:0];
    misaligned = 1'b0;
`ifdef LSU_MISALIGN_EXC_EN
    misaligned = op & (((size == SZ_H) & off[0]) | ((size == SZ_W) & (off != 2'd0)));
`else
    if (size == SZ_H)      off[0] = 1'b0;
    else if (size == SZ_W) off    = 2'd0;
`endif

    case (size)
      SZ_B:    wdata_lane = {4{wdata_i[7:0]}};
      SZ_H:    wdata_lane = {2{wdata_i[15:0]}};
      default: wdata_lane = wdata_i;
    endcase

    issue     = rst_n & op & ~misaligned & (state != RESP);
    grant     = issue & data_gnt_i;
    resp_done = rst_n & (state == RESP) & data_rvalid_i;
    mis_pulse = rst_n & op & misaligned & (state == IDLE);
  end

  lsu_load_align u_load_align (
    .load_type (ld_q),
    .offset    (off_q),
    .rdata     (data_rdata_i),
    .result    (load_result)
  );

  // Bus outputs follow the inputs combinationally while a request is pending.
  assign data_req_o   = issue;
  assign data_addr_o  = issue ? {addr_i[WORD_WIDTH-1:2], 2'b00} : '0;
  assign data_we_o    = issue & is_store & ~is_load;
  assign data_be_o    = issue ? be_gen(size, off) : 4'b0000;
  assign data_wdata_o = (issue & is_store & ~is_load) ? wdata_lane : '0;

  assign stall_o = rst_n & op & ~misaligned & ~resp_done;
  assign done_o  = resp_done | mis_pulse;
  assign rdata_o = (resp_done && ld_q != LD_NONE) ? load_result : '0;
`ifdef LSU_MISALIGN_EXC_EN
  assign misaligned_o = mis_pulse;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (issue) state_nxt = data_gnt_i ? RESP : REQ;
      REQ:     if (grant) state_nxt = RESP;
      RESP:    if (data_rvalid_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Lane offset and load kind are latched at grant for use when the response returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ld_q  <= 3'd0;
      off_q <= 2'd0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        ld_q  <= is_load ? load_type_i : 3'd0;
        off_q <= off;
      end
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed spec scenarios plus randomized transactions.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  load_type;
  logic [1:0]  store_type;
  logic [31:0] addr, wdata, rdata_in;
  logic        rvalid, gnt;
  logic        stall, done, req, we, misaligned;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  be;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.WORD_WIDTH(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_type_i   (load_type),
    .store_type_i  (store_type),
    .addr_i        (addr),
    .wdata_i       (wdata),
    .stall_o       (stall),
    .done_o        (done),
    .rdata_o       (rdata),
`ifdef LSU_MISALIGN_EXC_EN
    .misaligned_o  (misaligned),
`endif
    .data_req_o    (req),
    .data_addr_o   (mem_addr),
    .data_we_o     (we),
    .data_be_o     (be),
    .data_wdata_o  (mem_wdata),
    .data_rdata_i  (rdata_in),
    .data_rvalid_i (rvalid),
    .data_gnt_i    (gnt)
  );

`ifndef LSU_MISALIGN_EXC_EN
  assign misaligned = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Request fields are only meaningful while a request is expected.
  task automatic check_cycle(input string tag, input bit e_req, input logic [31:0] e_addr,
                             input bit e_we, input logic [3:0] e_be, input logic [31:0] e_wd,
                             input bit e_stall, input bit e_done, input logic [31:0] e_rd,
                             input bit e_mis);
    check({tag, ".req"}, {31'd0, req}, {31'd0, e_req});
    if (e_req) begin
      check({tag, ".addr"}, mem_addr, e_addr);
      check({tag, ".we"}, {31'd0, we}, {31'd0, e_we});
      check({tag, ".be"}, {28'd0, be}, {28'd0, e_be});
      if (e_we) check({tag, ".wdata"}, mem_wdata, e_wd);
    end
    check({tag, ".stall"}, {31'd0, stall}, {31'd0, e_stall});
    check({tag, ".done"}, {31'd0, done}, {31'd0, e_done});
    check({tag, ".rdata"}, rdata, e_rd);
    check({tag, ".mis"}, {31'd0, misaligned}, {31'd0, e_mis});
  endtask

  // Transaction-level reference: what one op should look like on the bus and at writeback.
  task automatic model(input logic [2:0] lt, input logic [1:0] st, input logic [31:0] a,
                       input logic [31:0] w, input logic [31:0] rd,
                       output bit op, output bit is_ld, output bit mis, output logic [31:0] e_addr,
                       output logic [3:0] e_be, output logic [31:0] e_wd, output logic [31:0] e_rd);
    int nbytes;
    int o;
    logic [31:0] sh;
    logic signed [7:0]  sb;
    logic signed [15:0] shw;
    is_ld  = (lt >= 3'd1 && lt <= 3'd5);
    op     = is_ld || (st != 2'd0);
    if (is_ld) nbytes = (lt == 3'd1 || lt == 3'd4) ? 1 : (lt == 3'd3) ? 4 : 2;
    else       nbytes = (st == 2'd1) ? 1 : (st == 2'd2) ? 2 : 4;
    o = int'(a[1:0]);
`ifdef LSU_MISALIGN_EXC_EN
    mis = op && (o % nbytes != 0);
`else
    mis = 1'b0;
    o   = o - (o % nbytes);
`endif
    e_addr = a & 32'hFFFF_FFFC;
    e_be   = 4'((1 << nbytes) - 1) << o;
    e_wd   = (nbytes == 1) ? w[7:0] * 32'h0101_0101 :
             (nbytes == 2) ? w[15:0] * 32'h0001_0001 : w;
    sh  = rd >> (8 * o);
    sb  = sh[7:0];
    shw = sh[15:0];
    case (lt)
      3'd1:    e_rd = 32'(sb);
      3'd4:    e_rd = sh & 32'h0000_00FF;
      3'd2:    e_rd = 32'(shw);
      3'd5:    e_rd = sh & 32'h0000_FFFF;
      3'd3:    e_rd = rd;
      default: e_rd = 32'd0;
    endcase
  endtask

  task automatic txn(input string tag, input logic [2:0] lt, input logic [1:0] st,
                     input logic [31:0] a, input logic [31:0] w, input logic [31:0] rd,
                     input int gdly, input int rdly);
    bit op, is_ld, mis, e_we;
    logic [31:0] e_addr, e_wd, e_rd;
    logic [3:0] e_be;
    model(lt, st, a, w, rd, op, is_ld, mis, e_addr, e_be, e_wd, e_rd);
    e_we = !is_ld && op;
    @(negedge clk);
    load_type = lt; store_type = st; addr = a; wdata = w;
    gnt = 1'b0; rvalid = 1'($urandom_range(0, 1)); rdata_in = $urandom;
    if (!op) begin
      #1 check_cycle({tag, ".none"}, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end else if (mis) begin
      #1 check_cycle({tag, ".mis"}, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    end else begin
      for (int c = 0; c <= gdly; c++) begin
        if (c > 0) @(negedge clk);
        gnt = (c == gdly); rvalid = 1'($urandom_range(0, 1)); rdata_in = $urandom;
        #1 check_cycle({tag, ".req"}, 1, e_addr, e_we, e_be, e_wd, 1, 0, 0, 0);
      end
      for (int k = 1; k <= rdly; k++) begin
        @(negedge clk);
        gnt = 1'b0; rvalid = (k == rdly); rdata_in = (k == rdly) ? rd : $urandom;
        if (k == rdly)
          #1 check_cycle({tag, ".done"}, 0, 0, 0, 0, 0, 0, 1, is_ld ? e_rd : 32'd0, 0);
        else
          #1 check_cycle({tag, ".wait"}, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      end
    end
  endtask

  task automatic idle_cycle(input string tag);
    @(negedge clk);
    load_type = 3'd0; store_type = 2'd0; gnt = 1'b0; rvalid = 1'b0;
    #1 check_cycle(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".req"}, {31'd0, req}, 32'd0);
    check({tag, ".addr"}, mem_addr, 32'd0);
    check({tag, ".we"}, {31'd0, we}, 32'd0);
    check({tag, ".be"}, {28'd0, be}, 32'd0);
    check({tag, ".wdata"}, mem_wdata, 32'd0);
    check({tag, ".stall"}, {31'd0, stall}, 32'd0);
    check({tag, ".done"}, {31'd0, done}, 32'd0);
    check({tag, ".rdata"}, rdata, 32'd0);
    check({tag, ".mis"}, {31'd0, misaligned}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    load_type = 3'd0; store_type = 2'd3; addr = 32'h104; wdata = 32'hDEAD_BEEF;
    rdata_in = 32'd0; rvalid = 1'b0; gnt = 1'b1;
    #12 check_all_zero("reset");
    @(negedge clk); rst_n = 1'b1; store_type = 2'd0; gnt = 1'b0;

    txn("sw",   3'd0, 2'd3, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0,         0, 1);
    txn("lb",   3'd1, 2'd0, 32'h0000_0203, 32'h0,         32'h8012_3456, 0, 1);
    txn("lbu",  3'd4, 2'd0, 32'h0000_0203, 32'h0,         32'h8012_3456, 0, 1);
    txn("sh",   3'd0, 2'd2, 32'h0000_0002, 32'h0000_1234, 32'h0,         3, 1);
    txn("lh",   3'd2, 2'd0, 32'h0000_0006, 32'h0,         32'h7FFF_0000, 0, 5);
    txn("lw",   3'd3, 2'd0, 32'h0000_0102, 32'h0,         32'hCAFE_F00D, 0, 1);
    txn("ldst", 3'd5, 2'd3, 32'h0000_0011, 32'h5555_AAAA, 32'h9ABC_8001, 1, 2);
    idle_cycle("gap");

    // Reset while waiting for a response; the late response must be dropped.
    @(negedge clk);
    load_type = 3'd2; store_type = 2'd0; addr = 32'h6; gnt = 1'b1; rvalid = 1'b0;
    #1 check({"rst.req"}, {31'd0, req}, 32'd1);
    @(negedge clk); gnt = 1'b0;
    #1 check("rst.resp_stall", {31'd0, stall}, 32'd1);
    @(negedge clk); rst_n = 1'b0;
    #1 check_all_zero("rst.a");
    @(negedge clk);
    #1 check_all_zero("rst.b");
    @(negedge clk); rst_n = 1'b1; load_type = 3'd0;
    #1 check_all_zero("rst.rel");
    @(negedge clk); rvalid = 1'b1; rdata_in = 32'h1234_5678;
    #1 check_all_zero("rst.late");
    txn("post_rst", 3'd3, 2'd0, 32'h0000_0040, 32'h0, 32'h0BAD_F00D, 0, 1);

    for (int i = 0; i < 300; i++) begin
      txn("rnd", 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom, $urandom,
          $urandom, int'($urandom_range(0, 3)), int'($urandom_range(1, 4)));
    end
    idle_cycle("end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
